flag_unit: RTL and testbench

Condition-flag unit for the pipelined CPU, sitting directly downstream of the two-cycle ALU control queue. It consumes the queue's flag-enable output together with the ALU's combinational flag results and holds the architectural NZCV register. It also runs a two-entry shadow pipeline of flag-setting instructions in flight. From that it generates the decode-stage stall and the forwarded flags that conditional branches need.

---
 rtl/flag_unit.sv | 57 +++++
 tb/tb_flag_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - NZCV flag register, two-stage shadow pipeline of in-flight setters, decode stall and flag forwarding.
// Optional build macro FLAG_FWD_EN enables the same-cycle commit bypass to decode.
module flag_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       FlagEI,
    input  logic       CondCheck,
    input  logic       FlagEO,
    input  logic [3:0] ALUFlags,
    output logic [3:0] Flags,
    output logic [3:0] FlagsFwd,
    output logic       FlagStall,
    output logic [1:0] Pending,
    output logic       FlagErr
);

    logic       s0_q, s0_d;
    logic       s1_q, s1_d;
    logic [3:0] flags_q, flags_d;
    logic       err_q, err_d;

    always_comb begin
        s0_d    = FlagEI & ~FlagStall;
        s1_d    = s0_q;
        flags_d = FlagEO ? ALUFlags : flags_q;
        // The shadow stage must line up exactly with the queue's own flag enable.
        err_d   = err_q | (s1_q != FlagEO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            flags_q <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

`ifdef FLAG_FWD_EN
    // The s1 producer commits this cycle and is bypassed, so only s0 blocks a B.cond.
    assign FlagStall = CondCheck & s0_q;
    assign FlagsFwd  = FlagEO ? ALUFlags : flags_q;
`else
    assign FlagStall = CondCheck & (s0_q | s1_q);
    assign FlagsFwd  = flags_q;
`endif

    assign Flags   = flags_q;
    assign Pending = {1'b0, s0_q} + {1'b0, s1_q};
    assign FlagErr = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - self-checking bench for flag_unit against a cycle-history reference model.
module tb_flag_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       FlagEI, CondCheck, FlagEO;
    logic [3:0] ALUFlags;
    logic [3:0] Flags, FlagsFwd;
    logic       FlagStall;
    logic [1:0] Pending;
    logic       FlagErr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycle numbers at which a setter was accepted into decode-to-ALU flight.
    int         cyc_n = 0;
    int         issued[$];
    logic [3:0] m_flags = 4'b0000;
    logic       m_err   = 1'b0;

    flag_unit dut (
        .clk(clk), .reset(reset), .FlagEI(FlagEI), .CondCheck(CondCheck),
        .FlagEO(FlagEO), .ALUFlags(ALUFlags), .Flags(Flags), .FlagsFwd(FlagsFwd),
        .FlagStall(FlagStall), .Pending(Pending), .FlagErr(FlagErr)
    );

    always #5 clk = ~clk;

    function automatic bit issued_ago(int age);
        foreach (issued[i]) if (issued[i] == cyc_n - age) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
`ifdef FLAG_FWD_EN
        return CondCheck && issued_ago(1);
`else
        return CondCheck && (issued_ago(1) || issued_ago(2));
`endif
    endfunction

    function automatic logic [1:0] m_pending();
        int n = 0;
        if (issued_ago(1)) n++;
        if (issued_ago(2)) n++;
        return 2'(n);
    endfunction

    function automatic logic [3:0] m_fwd();
`ifdef FLAG_FWD_EN
        return FlagEO ? ALUFlags : m_flags;
`else
        return m_flags;
`endif
    endfunction

    task automatic drive(input logic ei, input logic cc, input logic eo, input logic [3:0] alu);
        FlagEI = ei; CondCheck = cc; FlagEO = eo; ALUFlags = alu;
        #2;
    endtask

    task automatic tick();
        bit st;
        st = m_stall();
        if (FlagEI && !st) issued.push_back(cyc_n);
        if (FlagEO) m_flags = ALUFlags;
        if (issued_ago(2) != FlagEO) m_err = 1'b1;
        @(posedge clk);
        cyc_n++;
        while (issued.size() > 0 && issued[0] < cyc_n - 2) void'(issued.pop_front());
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        issued.delete();
        m_flags = 4'b0000;
        m_err   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'b1111);
        n_checks++; if (Flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
        n_checks++; if (FlagsFwd !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd got=%b exp=0000", FlagsFwd); end
        n_checks++; if (Pending !== 2'd0) begin n_fail++; $display("FAIL reset_pending got=%0d exp=0", Pending); end
        n_checks++; if (FlagStall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", FlagStall); end
        n_checks++; if (FlagErr !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", FlagErr); end
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        @(posedge clk); #1;
        reset = 1'b0;
        issued.delete(); m_flags = 4'b0000; m_err = 1'b0;
    endtask

    task automatic test_adjacent();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 4'b0000); tick();
        drive(1'b0, 1'b1, 1'b0, 4'b0000);
        n_checks++; if (FlagStall !== 1'b1) begin n_fail++; $display("FAIL adj_stall_c1 got=%b exp=1", FlagStall); end
        tick();
        drive(1'b0, 1'b1, 1'b1, 4'b0100);
`ifdef FLAG_FWD_EN
        n_checks++; if (FlagStall !== 1'b0) begin n_fail++; $display("FAIL adj_stall_c2 got=%b exp=0", FlagStall); end
        n_checks++; if (FlagsFwd !== 4'b0100) begin n_fail++; $display("FAIL adj_fwd_c2 got=%b exp=0100", FlagsFwd); end
`else
        n_checks++; if (FlagStall !== 1'b1) begin n_fail++; $display("FAIL adj_stall_c2 got=%b exp=1", FlagStall); end
        n_checks++; if (FlagsFwd !== 4'b0000) begin n_fail++; $display("FAIL adj_fwd_c2 got=%b exp=0000", FlagsFwd); end
`endif
        tick();
        drive(1'b0, 1'b1, 1'b0, 4'b0000);
        n_checks++; if (FlagStall !== 1'b0) begin n_fail++; $display("FAIL adj_stall_c3 got=%b exp=0", FlagStall); end
        n_checks++; if (FlagsFwd !== 4'b0100) begin n_fail++; $display("FAIL adj_fwd_c3 got=%b exp=0100", FlagsFwd); end
        n_checks++; if (Flags !== 4'b0100) begin n_fail++; $display("FAIL adj_flags_c3 got=%b exp=0100", Flags); end
        tick();
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'b1111);
            tick();
            n_checks++; if (Flags !== 4'b0100) begin n_fail++; $display("FAIL hold_flags_%0d got=%b exp=0100", i, Flags); end
            n_checks++; if (Pending !== 2'd0) begin n_fail++; $display("FAIL hold_pending_%0d got=%0d exp=0", i, Pending); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 4'b0000); tick();
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        n_checks++; if (Pending !== 2'd1) begin n_fail++; $display("FAIL b2b_pending_c1 got=%0d exp=1", Pending); end
        tick();
        drive(1'b0, 1'b0, 1'b1, 4'b1000);
        n_checks++; if (Pending !== 2'd2) begin n_fail++; $display("FAIL b2b_pending_c2 got=%0d exp=2", Pending); end
        tick();
        drive(1'b0, 1'b0, 1'b1, 4'b0010);
        n_checks++; if (Pending !== 2'd1) begin n_fail++; $display("FAIL b2b_pending_c3 got=%0d exp=1", Pending); end
        n_checks++; if (Flags !== 4'b1000) begin n_fail++; $display("FAIL b2b_flags_c3 got=%b exp=1000", Flags); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        n_checks++; if (Flags !== 4'b0010) begin n_fail++; $display("FAIL b2b_flags_c4 got=%b exp=0010", Flags); end
        n_checks++; if (FlagErr !== 1'b0) begin n_fail++; $display("FAIL b2b_err got=%b exp=0", FlagErr); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 4'b0000); tick();
        drive(1'b1, 1'b0, 1'b1, 4'b0110); tick();
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        n_checks++; if (Pending !== 2'd2) begin n_fail++; $display("FAIL arst_pre_pending got=%0d exp=2", Pending); end
        reset = 1'b1;
        #1;
        n_checks++; if (Pending !== 2'd0) begin n_fail++; $display("FAIL arst_pending got=%0d exp=0", Pending); end
        n_checks++; if (Flags !== 4'b0000) begin n_fail++; $display("FAIL arst_flags got=%b exp=0000", Flags); end
        n_checks++; if (FlagErr !== 1'b0) begin n_fail++; $display("FAIL arst_err got=%b exp=0", FlagErr); end
        reset = 1'b0;
        issued.delete(); m_flags = 4'b0000; m_err = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_err();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 4'b1010);
        n_checks++; if (FlagErr !== 1'b0) begin n_fail++; $display("FAIL err_before got=%b exp=0", FlagErr); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        n_checks++; if (FlagErr !== 1'b1) begin n_fail++; $display("FAIL err_set got=%b exp=1", FlagErr); end
        n_checks++; if (Flags !== 4'b1010) begin n_fail++; $display("FAIL err_flags got=%b exp=1010", Flags); end
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (FlagErr !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", FlagErr); end
        do_reset();
        n_checks++; if (FlagErr !== 1'b0) begin n_fail++; $display("FAIL err_cleared got=%b exp=0", FlagErr); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic eo;
            eo = issued_ago(2);
            if ($urandom_range(0, 49) == 0) eo = ~eo;
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), eo, 4'($urandom));
            n_checks++; if (FlagStall !== m_stall()) begin n_fail++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, FlagStall, m_stall()); end
            n_checks++; if (Pending !== m_pending()) begin n_fail++; $display("FAIL rnd_pending cyc=%0d got=%0d exp=%0d", i, Pending, m_pending()); end
            n_checks++; if (FlagsFwd !== m_fwd()) begin n_fail++; $display("FAIL rnd_fwd cyc=%0d got=%b exp=%b", i, FlagsFwd, m_fwd()); end
            n_checks++; if (Flags !== m_flags) begin n_fail++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, Flags, m_flags); end
            n_checks++; if (FlagErr !== m_err) begin n_fail++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, FlagErr, m_err); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        FlagEI = 1'b0; CondCheck = 1'b0; FlagEO = 1'b0; ALUFlags = 4'b0000;
        #12;
        test_reset();
        test_adjacent();
        test_hold();
        test_back_to_back();
        test_async_reset();
        test_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
